ahb_reg_slave: RTL and testbench
================================

# ahb_reg_slave

AHB-lite responder terminating the slave port of the interconnect transaction path. It holds a bank of 32-bit registers with a configurable number of wait states and a two-cycle ERROR response for illegal accesses. The top register is read-only and records the master ID of the last completed write. It is the default endpoint used to exercise and verify the monitor path end to end.

## Interface
- `NREGS`, default 16: number of 32-bit registers; must be a power of two, minimum 2. Register `NREGS-1` is the read-only master-ID register.
- `WAIT_STATES`, default 1: data-phase wait cycles for OKAY transfers, range 0..7.
- `BASE_ADDR`, default 32'h0000_0000: byte base address; must be aligned to `NREGS*4`.

Ports:
- `hclk`, input, 1: clock. Single clock domain; all logic on the rising edge.
- `hreset`, input, 1: reset, synchronous and active-high.
- `hsel`, input, 1: transfer request. Only non-sequential transfers are used, so `hsel` alone marks a valid address phase.
- `hmaster`, input, 32: master ID of the address phase.
- `haddr`, input, 32: byte address.
- `hsize`, input, 3: 0 = byte, 1 = half-word, 2 = word.
- `hwrite`, input, 1: 1 = write, 0 = read.
- `hwdata`, input, 32: write data, valid in the data phase.
- `hrdata`, output, 32: read data.
- `hready`, output, 1: 0 stalls the data phase. This output is also the bus ready.
- `hresp`, output, 1: 1 = ERROR.

## Operation
- **Address-phase accept:** `hsel=1` while this block drives `hready=1`. On accept, latch `haddr`, `hsize`, `hwrite` and `hmaster`.
- **Decode:** offset = `haddr - BASE_ADDR`; index = offset[log2(NREGS)+1:2].
- **Illegal access**, any of the following:
  - offset ≥ `NREGS*4` (unsigned);
  - `hsize` > 2;
  - `hsize`=1 with `haddr[0]`=1;
  - `hsize`=2 with `haddr[1:0]`≠0;
  - write to index `NREGS-1`.
- **FSM states:**
  - IDLE: `hready`=1, `hresp`=0.
  - WAIT: `hready`=0, `hresp`=0; cycle counter counting down.
  - DATA: `hready`=1, `hresp`=0.
  - ERR1: `hready`=0, `hresp`=1.
  - ERR2: `hready`=1, `hresp`=1.
- **Transitions:** states IDLE, DATA and ERR2 can accept a new address phase.
  - On accept, a legal access goes to WAIT with the counter loaded to `WAIT_STATES-1`, or directly to DATA if `WAIT_STATES`=0.
  - On accept, an illegal access goes to ERR1.
  - IDLE, DATA or ERR2 with no accept goes to IDLE.
  - WAIT goes to DATA when the counter is 0; otherwise the counter decrements.
  - ERR1 always goes to ERR2.
- **Writes:** commit on the DATA cycle edge, using byte lanes selected by size and `haddr[1:0]` (little-endian).
  - byte: lane `haddr[1:0]`.
  - half-word: lanes {1,0} or {3,2}.
  - word: all lanes.
  - Unselected bytes are unchanged.
  - On the same edge, register `NREGS-1` is loaded with the latched `hmaster`.
- **Reads:** `hrdata` = full 32-bit register word during DATA. `hrdata` = 0 in every other state, including ERR1 and ERR2.
- **Errored transfers:** never modify any register.
- **Back-to-back hazard:** a read accepted during a write's DATA cycle to the same register returns the newly written value.

## Timing
- **Reset values:** `hready`=1, `hresp`=0, `hrdata`=0, state IDLE, all registers 0 (including the master-ID register).
- **Reset priority:** reset overrides all activity. A transfer in flight when `hreset` is sampled high is abandoned with no write commit, and the block returns to IDLE on the next cycle.
- **OKAY latency:** the data phase lasts `WAIT_STATES+1` cycles after the accept edge. With `WAIT_STATES`=0 there are zero stall cycles.
- **ERROR latency:** always exactly 2 cycles (ERR1, then ERR2), independent of `WAIT_STATES`.
- **Pipelining:** a new address phase may be accepted in a DATA or ERR2 cycle. The next transfer's data phase then begins on the following cycle with no bubble.
- **Stalled inputs:** `hsel` is ignored while `hready`=0. Address-phase inputs during WAIT or ERR1 are not sampled.
- **Write-data sampling:** `hwdata` is sampled only on the DATA edge, so the master may hold it through WAIT.

## Test plan
- **Reset:** assert `hreset` for 2 cycles mid-way through a WAIT on a write of 32'hDEAD_BEEF to index 3 → no commit; `hready`=1, `hresp`=0 and `hrdata`=0 next cycle; index 3 reads back 0.
- **Word write/read, `WAIT_STATES`=1:**
  - Write 32'h1234_5678 to offset 0x8 with `hmaster`=32'h5 → `hready` low for 1 cycle, then high.
  - Read offset 0x8 → 32'h1234_5678.
  - Read offset 0x3C → 32'h0000_0005.
- **Byte and half-word lanes:** starting from register 2 = 32'h0 (offset 0x8 = index 2):
  - byte write 8'hAB at 0xA;
  - half-word write 16'hCDEF at 0x8;
  - read 0x8 → 32'h00AB_CDEF.
- **Errors:** each of the following gives exactly ERR1 (`hready`=0, `hresp`=1) then ERR2 (`hready`=1, `hresp`=1), leaves registers unchanged, and returns `hrdata`=0:
  - word access at 0x2;
  - access at offset 0x40;
  - `hsize`=3;
  - write to 0x3C.
- **Pipelined, `WAIT_STATES`=0:**
  - Write 32'hA5A5_0001 to 0x4, with a read of 0x4 accepted in the write's DATA cycle → read returns 32'hA5A5_0001, no stall cycles.
  - An error transfer accepted in a DATA cycle → data phase starts on the following cycle with no bubble.

Source files
------------

// File: rtl/ahb_reg_slave.sv
// AHB-lite register responder: NREGS x 32-bit register bank, programmable
// OKAY wait states, two-cycle ERROR response, and a read-only top register
// that captures the master ID of the last committed write.
module ahb_reg_slave #(
  parameter int unsigned NREGS       = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] hmaster,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int unsigned IW       = $clog2(NREGS);
  localparam logic [31:0] REGION   = 32'(NREGS * 4);
  localparam logic [IW-1:0] ID_IDX = IW'(NREGS - 1);
  localparam logic [2:0]  WS_LOAD  = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [IW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          wr_q;
  logic [31:0]   master_q;

  logic [31:0]   regs [NREGS];

  logic [31:0]   offset;
  logic [IW-1:0] idx;
  logic          out_of_range;
  logic          illegal;
  logic          accept;
  logic          commit;
  logic [3:0]    be;

  // Address-phase decode and legality check on the live bus inputs
  always_comb begin
    offset       = haddr - BASE_ADDR;
    idx          = offset[IW+1:2];
    out_of_range = (offset >= REGION);
    illegal      = out_of_range
                 || (hsize > 3'd2)
                 || ((hsize == 3'd1) && haddr[0])
                 || ((hsize == 3'd2) && (haddr[1:0] != 2'b00))
                 || (hwrite && !out_of_range && (idx == ID_IDX));
    accept       = hsel && hready;
    commit       = (state == S_DATA) && wr_q;
  end

  // Transfer FSM with registered hready/hresp; address phase latched on accept
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= S_IDLE;
      hready   <= 1'b1;
      hresp    <= 1'b0;
      cnt      <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      master_q <= '0;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            state  <= S_DATA;
            hready <= 1'b1;
            hresp  <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          hready <= 1'b1;
          hresp  <= 1'b1;
        end
        default: begin
          if (accept) begin
            idx_q    <= idx;
            lane_q   <= haddr[1:0];
            size_q   <= hsize[1:0];
            wr_q     <= hwrite;
            master_q <= hmaster;
            if (illegal) begin
              state  <= S_ERR1;
              hready <= 1'b0;
              hresp  <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state  <= S_DATA;
              hready <= 1'b1;
              hresp  <= 1'b0;
            end else begin
              state  <= S_WAIT;
              cnt    <= WS_LOAD;
              hready <= 1'b0;
              hresp  <= 1'b0;
            end
          end else begin
            state  <= S_IDLE;
            hready <= 1'b1;
            hresp  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Little-endian byte-lane enables from the latched size and address LSBs
  always_comb begin
    be = '0;
    unique case (size_q)
      2'd0:    be[lane_q] = 1'b1;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Register bank: byte-lane write on the DATA edge, master ID captured alongside
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          regs[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
      regs[NREGS-1] <= master_q;
    end
  end

  // Read data is combinational from the bank so a read pipelined behind a
  // write to the same register sees the value committed on the accept edge
  always_comb begin
    hrdata = (state == S_DATA) ? regs[idx_q] : '0;
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Self-checking bench for ahb_reg_slave: one instance with one wait state for
// the table-driven vectors and reset checks, one with zero wait states for
// the pipelined sequences.
module tb_ahb_reg_slave;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel1, hsel0;
  logic [31:0] hmaster;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata1, hrdata0;
  logic        hready1, hready0;
  logic        hresp1, hresp0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 hclk = ~hclk;

  ahb_reg_slave #(.NREGS(16), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel1), .hmaster(hmaster),
    .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata1), .hready(hready1), .hresp(hresp1)
  );

  ahb_reg_slave #(.NREGS(16), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .hmaster(hmaster),
    .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] master;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample(input bit ws0, output logic rdy, output logic rsp, output logic [31:0] rd);
    @(negedge hclk);
    rdy = ws0 ? hready0 : hready1;
    rsp = ws0 ? hresp0  : hresp1;
    rd  = ws0 ? hrdata0 : hrdata1;
  endtask

  task automatic pop_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got %h expected <scoreboard empty>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic next_edge();
    @(posedge hclk);
    #1;
  endtask

  // One non-pipelined transfer starting from an idle bus
  task automatic xfer(input bit ws0, input logic [31:0] addr, input logic [2:0] size,
                      input logic wr, input logic [31:0] wdata, input logic [31:0] master,
                      input logic exp_err, input logic [31:0] exp_rd, input string name);
    logic rdy, rsp;
    logic [31:0] rd;
    int stalls;
    haddr   = addr;
    hsize   = size;
    hwrite  = wr;
    hmaster = master;
    hwdata  = '0;
    if (ws0) hsel0 = 1'b1; else hsel1 = 1'b1;
    if (!wr || exp_err) exp_q.push_back(exp_err ? 32'h0 : exp_rd);
    next_edge();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    hwdata = wdata;
    haddr  = ~addr;
    hsize  = 3'd7;
    if (exp_err) begin
      sample(ws0, rdy, rsp, rd);
      check({name, " err1 rdy/rsp"}, {30'd0, rdy, rsp}, 32'd1);
      check({name, " err1 rdata"}, rd, 32'h0);
      next_edge();
      sample(ws0, rdy, rsp, rd);
      check({name, " err2 rdy/rsp"}, {30'd0, rdy, rsp}, 32'd3);
      pop_check({name, " err2 rdata"}, rd);
    end else begin
      stalls = 0;
      sample(ws0, rdy, rsp, rd);
      while (!rdy && stalls < 16) begin
        stalls++;
        next_edge();
        sample(ws0, rdy, rsp, rd);
      end
      check({name, " stalls"}, 32'(stalls), ws0 ? 32'd0 : 32'd1);
      check({name, " hresp"}, {31'd0, rsp}, 32'd0);
      if (!wr) pop_check({name, " rdata"}, rd);
    end
    next_edge();
    hwdata = '0;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [2:0] s, input logic w,
                              input logic [31:0] d, input logic [31:0] m,
                              input logic e, input logic [31:0] r);
    vec_t v;
    v.addr = a; v.size = s; v.wr = w; v.wdata = d; v.master = m; v.err = e; v.rd = r;
    return v;
  endfunction

  initial begin
    logic rdy, rsp;
    logic [31:0] rd;

    tbl[0]  = mk(32'h08, 3'd2, 1'b1, 32'h1234_5678, 32'h5, 1'b0, 32'h0);
    tbl[1]  = mk(32'h08, 3'd2, 1'b0, 32'h0,         32'h5, 1'b0, 32'h1234_5678);
    tbl[2]  = mk(32'h3C, 3'd2, 1'b0, 32'h0,         32'h5, 1'b0, 32'h0000_0005);
    tbl[3]  = mk(32'h08, 3'd2, 1'b1, 32'h0,         32'h7, 1'b0, 32'h0);
    tbl[4]  = mk(32'h0A, 3'd0, 1'b1, 32'h00AB_0000, 32'h7, 1'b0, 32'h0);
    tbl[5]  = mk(32'h08, 3'd1, 1'b1, 32'h0000_CDEF, 32'h9, 1'b0, 32'h0);
    tbl[6]  = mk(32'h08, 3'd2, 1'b0, 32'h0,         32'h9, 1'b0, 32'h00AB_CDEF);
    tbl[7]  = mk(32'h3C, 3'd2, 1'b0, 32'h0,         32'h9, 1'b0, 32'h0000_0009);
    tbl[8]  = mk(32'h02, 3'd2, 1'b0, 32'h0,         32'h1, 1'b1, 32'h0);
    tbl[9]  = mk(32'h40, 3'd2, 1'b0, 32'h0,         32'h1, 1'b1, 32'h0);
    tbl[10] = mk(32'h08, 3'd3, 1'b0, 32'h0,         32'h1, 1'b1, 32'h0);
    tbl[11] = mk(32'h3C, 3'd2, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0);
    tbl[12] = mk(32'h09, 3'd1, 1'b1, 32'h1111_1111, 32'h1, 1'b1, 32'h0);
    tbl[13] = mk(32'h08, 3'd2, 1'b0, 32'h0,         32'h1, 1'b0, 32'h00AB_CDEF);
    tbl[14] = mk(32'h3C, 3'd2, 1'b0, 32'h0,         32'h1, 1'b0, 32'h0000_0009);

    hreset = 1'b1; hsel1 = 1'b0; hsel0 = 1'b0; hmaster = '0;
    haddr = '0; hsize = '0; hwrite = 1'b0; hwdata = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("reset ws1 rdy/rsp", {30'd0, hready1, hresp1}, 32'd2);
    check("reset ws1 rdata", hrdata1, 32'h0);
    check("reset ws0 rdy/rsp", {30'd0, hready0, hresp0}, 32'd2);
    check("reset ws0 rdata", hrdata0, 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    next_edge();

    for (int i = 0; i < 15; i++) begin
      xfer(1'b0, tbl[i].addr, tbl[i].size, tbl[i].wr, tbl[i].wdata, tbl[i].master,
           tbl[i].err, tbl[i].rd, $sformatf("vec%0d", i));
    end

    // Pipelined write then read of the same register, zero wait states
    haddr = 32'h4; hsize = 3'd2; hwrite = 1'b1; hmaster = 32'h2; hsel0 = 1'b1;
    next_edge();
    hwdata = 32'hA5A5_0001; hwrite = 1'b0; hmaster = 32'h3;
    exp_q.push_back(32'hA5A5_0001);
    sample(1'b1, rdy, rsp, rd);
    check("pipe wr data rdy/rsp", {30'd0, rdy, rsp}, 32'd2);
    next_edge();
    hsel0 = 1'b0;
    sample(1'b1, rdy, rsp, rd);
    check("pipe rd rdy/rsp", {30'd0, rdy, rsp}, 32'd2);
    pop_check("pipe rd hazard rdata", rd);
    next_edge();

    // Error transfer accepted in a write's DATA cycle
    haddr = 32'h10; hsize = 3'd2; hwrite = 1'b1; hmaster = 32'h6; hsel0 = 1'b1;
    next_edge();
    hwdata = 32'h1357_9BDF; haddr = 32'h2; hwrite = 1'b0; hmaster = 32'h8;
    sample(1'b1, rdy, rsp, rd);
    check("pipe err prev data rdy/rsp", {30'd0, rdy, rsp}, 32'd2);
    next_edge();
    hsel0 = 1'b0; hwdata = '0;
    sample(1'b1, rdy, rsp, rd);
    check("pipe err1 rdy/rsp", {30'd0, rdy, rsp}, 32'd1);
    check("pipe err1 rdata", rd, 32'h0);
    next_edge();
    sample(1'b1, rdy, rsp, rd);
    check("pipe err2 rdy/rsp", {30'd0, rdy, rsp}, 32'd3);
    check("pipe err2 rdata", rd, 32'h0);
    next_edge();
    xfer(1'b1, 32'h10, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1357_9BDF, "ws0 rd 0x10");
    xfer(1'b1, 32'h3C, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0006, "ws0 rd id");
    xfer(1'b1, 32'h04, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'hA5A5_0001, "ws0 rd 0x4");

    // Reset asserted during the WAIT of a write: no commit, back to IDLE
    haddr = 32'hC; hsize = 3'd2; hwrite = 1'b1; hmaster = 32'h3; hsel1 = 1'b1;
    next_edge();
    hsel1 = 1'b0; hwdata = 32'hDEAD_BEEF; hreset = 1'b1;
    sample(1'b0, rdy, rsp, rd);
    check("rst wait rdy", {31'd0, rdy}, 32'd0);
    next_edge();
    sample(1'b0, rdy, rsp, rd);
    check("rst after rdy/rsp", {30'd0, rdy, rsp}, 32'd2);
    check("rst after rdata", rd, 32'h0);
    next_edge();
    hreset = 1'b0; hwdata = '0;
    next_edge();
    xfer(1'b0, 32'h0C, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "rst rd idx3");
    xfer(1'b0, 32'h08, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "rst rd idx2");
    xfer(1'b0, 32'h3C, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "rst rd id");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
